// File: rtl/tcdm_rr_arbiter.sv
// N-to-1 TCDM round-robin arbiter: one slave port shared by NR_INPUTS requesters, one outstanding read.
// Latency: request/grant and read response paths are purely combinational (zero added cycles).
// Backpressure: ungranted requests lock the winner; no new issue until the pending read response is accepted.
module tcdm_rr_arbiter #(
    parameter int unsigned NR_INPUTS  = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                                  clk_i,
    input  logic                                  resetn_i,

    input  logic [NR_INPUTS-1:0]                  master_req_i,
    output logic [NR_INPUTS-1:0]                  master_gnt_o,
    input  logic [NR_INPUTS-1:0][ADDR_WIDTH-1:0]  master_addr_i,
    input  logic [NR_INPUTS-1:0]                  master_wen_i,
    input  logic [NR_INPUTS-1:0][DATA_WIDTH-1:0]  master_data_i,
    input  logic [NR_INPUTS-1:0][BE_WIDTH-1:0]    master_be_i,
    output logic [NR_INPUTS-1:0][DATA_WIDTH-1:0]  master_r_data_o,
    output logic [NR_INPUTS-1:0]                  master_r_valid_o,
    input  logic [NR_INPUTS-1:0]                  master_r_ready_i,

    output logic                                  slave_req_o,
    input  logic                                  slave_gnt_i,
    output logic [ADDR_WIDTH-1:0]                 slave_addr_o,
    output logic                                  slave_wen_o,
    output logic [DATA_WIDTH-1:0]                 slave_data_o,
    output logic [BE_WIDTH-1:0]                   slave_be_o,
    input  logic [DATA_WIDTH-1:0]                 slave_r_data_i,
    input  logic                                  slave_r_valid_i,
    output logic                                  slave_r_ready_o
);

    localparam int unsigned SEL_WIDTH = $clog2(NR_INPUTS);

    typedef logic [SEL_WIDTH-1:0] sel_t;
    typedef logic [SEL_WIDTH:0]   cand_t;
    typedef enum logic {IDLE, PENDING} state_t;

    state_t state_q, state_d;
    sel_t   rr_ptr_q, rr_ptr_d;
    sel_t   owner_q, owner_d;
    logic   locked_q, locked_d;
    sel_t   lock_idx_q, lock_idx_d;

    sel_t   rr_winner;
    sel_t   winner;
    logic   any_req;
    logic   rsp_hs;
    logic   can_issue;
    logic   issue;
    logic   grant;
    cand_t  cand;
    logic   found;

    // Round-robin scan starting at rr_ptr_q; the candidate index wraps at NR_INPUTS, never past it.
    always_comb begin
        rr_winner = rr_ptr_q;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NR_INPUTS; k++) begin
            cand = {1'b0, rr_ptr_q} + cand_t'(k);
            if (cand >= cand_t'(NR_INPUTS)) begin
                cand = cand - cand_t'(NR_INPUTS);
            end
            if (!found && master_req_i[cand[SEL_WIDTH-1:0]]) begin
                rr_winner = cand[SEL_WIDTH-1:0];
                found     = 1'b1;
            end
        end
    end

    assign winner    = locked_q ? lock_idx_q : rr_winner;
    assign any_req   = |master_req_i;
    assign rsp_hs    = (state_q == PENDING) && slave_r_valid_i && master_r_ready_i[owner_q];
    assign can_issue = (state_q == IDLE) || rsp_hs;
    // Issue is masked while reset is held so nothing leaks to the slave during reset.
    assign issue     = resetn_i && can_issue && any_req;
    assign grant     = issue && slave_gnt_i;

    assign slave_req_o  = issue;
    assign slave_addr_o = master_addr_i[winner];
    assign slave_wen_o  = master_wen_i[winner];
    assign slave_data_o = master_data_i[winner];
    assign slave_be_o   = master_be_i[winner];

    always_comb begin
        master_gnt_o     = '0;
        master_r_valid_o = '0;
        master_r_data_o  = '0;
        slave_r_ready_o  = 1'b0;
        if (grant) begin
            master_gnt_o[winner] = 1'b1;
        end
        if (state_q == PENDING) begin
            master_r_valid_o[owner_q] = slave_r_valid_i;
            master_r_data_o[owner_q]  = slave_r_data_i;
            slave_r_ready_o           = master_r_ready_i[owner_q];
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (rsp_hs) begin
            state_d = IDLE;
        end
        if (issue) begin
            if (slave_gnt_i) begin
                rr_ptr_d = (winner == sel_t'(NR_INPUTS - 1)) ? '0 : winner + sel_t'(1);
                locked_d = 1'b0;
                if (!slave_wen_o) begin
                    owner_d = winner;
                    state_d = PENDING;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                // Hold the winner so address/data stay stable at the slave until granted.
                locked_d   = 1'b1;
                lock_idx_d = winner;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Directed bench for tcdm_rr_arbiter with three requesters (non-power-of-two wrap).
module tb_tcdm_rr_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    logic                  clk;
    logic                  resetn;
    logic [N-1:0]          req;
    logic [N-1:0]          gnt;
    logic [N-1:0][AW-1:0]  addr;
    logic [N-1:0]          wen;
    logic [N-1:0][DW-1:0]  wdata;
    logic [N-1:0][BW-1:0]  be;
    logic [N-1:0][DW-1:0]  r_data;
    logic [N-1:0]          r_valid;
    logic [N-1:0]          r_ready;
    logic                  s_req;
    logic                  s_gnt;
    logic [AW-1:0]         s_addr;
    logic                  s_wen;
    logic [DW-1:0]         s_data;
    logic [BW-1:0]         s_be;
    logic [DW-1:0]         s_r_data;
    logic                  s_r_valid;
    logic                  s_r_ready;

    int n_checks = 0;
    int n_fail   = 0;

    tcdm_rr_arbiter #(
        .NR_INPUTS (N),
        .DATA_WIDTH(DW),
        .BE_WIDTH  (BW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_i           (clk),
        .resetn_i        (resetn),
        .master_req_i    (req),
        .master_gnt_o    (gnt),
        .master_addr_i   (addr),
        .master_wen_i    (wen),
        .master_data_i   (wdata),
        .master_be_i     (be),
        .master_r_data_o (r_data),
        .master_r_valid_o(r_valid),
        .master_r_ready_i(r_ready),
        .slave_req_o     (s_req),
        .slave_gnt_i     (s_gnt),
        .slave_addr_o    (s_addr),
        .slave_wen_o     (s_wen),
        .slave_data_o    (s_data),
        .slave_be_o      (s_be),
        .slave_r_data_i  (s_r_data),
        .slave_r_valid_i (s_r_valid),
        .slave_r_ready_o (s_r_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn    = 1'b1;
        req       = '0;
        wen       = '1;
        wdata     = '0;
        be        = '1;
        r_ready   = '1;
        s_gnt     = 1'b1;
        s_r_data  = '0;
        s_r_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            addr[i]  = 32'h100 * i;
            wdata[i] = 32'hA000_0000 + i;
        end
        #1 resetn = 1'b0;

        // Reset held with every port requesting.
        req = '1;
        tick();
        tick();
        #1;
        check_eq("rst_gnt", gnt, 3'b000);
        check_eq("rst_sreq", s_req, 1'b0);
        check_eq("rst_rvalid", r_valid, 3'b000);
        check_eq("rst_rready", s_r_ready, 1'b0);

        // Release; continuous writes rotate 0,1,2,0,1,2.
        tick();
        resetn = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("rr_gnt%0d", i), gnt, 3'b001 << (i % 3));
            check_eq($sformatf("rr_addr%0d", i), s_addr, 32'h100 * (i % 3));
            tick();
        end
        req = '0;

        // Lock: port 1 read 0x40 stalls three cycles while port 0 joins.
        addr[1] = 32'h40;
        wen[1]  = 1'b0;
        req[1]  = 1'b1;
        s_gnt   = 1'b0;
        #1;
        check_eq("lock_c1_addr", s_addr, 32'h40);
        check_eq("lock_c1_gnt", gnt, 3'b000);
        tick();
        req[0] = 1'b1;
        #1;
        check_eq("lock_c2_addr", s_addr, 32'h40);
        check_eq("lock_c2_wen", s_wen, 1'b0);
        check_eq("lock_c2_gnt", gnt, 3'b000);
        tick();
        #1;
        check_eq("lock_c3_addr", s_addr, 32'h40);
        check_eq("lock_c3_gnt", gnt, 3'b000);
        tick();
        s_gnt = 1'b1;
        #1;
        check_eq("lock_c4_gnt", gnt, 3'b010);
        check_eq("lock_c4_addr", s_addr, 32'h40);
        tick();

        // Read routing: response arrives on the second cycle after grant.
        req = '0;
        #1;
        check_eq("rd_wait_sreq", s_req, 1'b0);
        check_eq("rd_wait_rvalid", r_valid, 3'b000);
        tick();
        s_r_valid = 1'b1;
        s_r_data  = 32'hDEAD_BEEF;
        #1;
        check_eq("rd_rvalid", r_valid, 3'b010);
        check_eq("rd_rdata1", r_data[1], 32'hDEAD_BEEF);
        check_eq("rd_rdata0", r_data[0], 32'h0);
        check_eq("rd_rready", s_r_ready, 1'b1);
        tick();
        s_r_valid = 1'b0;

        // Back-to-back: port 0 read (pointer at 2 wraps to 0), then port 1 read on the handshake.
        addr[0] = 32'h80;
        wen[0]  = 1'b0;
        req[0]  = 1'b1;
        #1;
        check_eq("b2b_gnt0", gnt, 3'b001);
        tick();
        req[0]  = 1'b0;
        addr[1] = 32'hC0;
        req[1]  = 1'b1;
        #1;
        check_eq("b2b_hold_gnt", gnt, 3'b000);
        check_eq("b2b_hold_sreq", s_req, 1'b0);
        tick();
        s_r_valid = 1'b1;
        s_r_data  = 32'h1111_1111;
        #1;
        check_eq("b2b_gnt1", gnt, 3'b010);
        check_eq("b2b_rvalid0", r_valid, 3'b001);
        check_eq("b2b_rdata0", r_data[0], 32'h1111_1111);
        tick();
        req[1]   = 1'b0;
        s_r_data = 32'h2222_2222;
        #1;
        check_eq("b2b_rvalid1", r_valid, 3'b010);
        check_eq("b2b_rdata1", r_data[1], 32'h2222_2222);
        tick();
        s_r_valid = 1'b0;

        // Backpressure: port 2 read, owner stalls the response two cycles.
        addr[2] = 32'hE0;
        wen[2]  = 1'b0;
        req[2]  = 1'b1;
        #1;
        check_eq("bp_gnt2", gnt, 3'b100);
        tick();
        req[2]     = 1'b0;
        addr[0]    = 32'h10;
        wen[0]     = 1'b1;
        req[0]     = 1'b1;
        s_r_valid  = 1'b1;
        s_r_data   = 32'h3333_3333;
        r_ready[2] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_eq($sformatf("bp_gnt_c%0d", i), gnt, 3'b000);
            check_eq($sformatf("bp_sreq_c%0d", i), s_req, 1'b0);
            check_eq($sformatf("bp_rvalid_c%0d", i), r_valid, 3'b100);
            check_eq($sformatf("bp_rready_c%0d", i), s_r_ready, 1'b0);
            tick();
        end
        r_ready[2] = 1'b1;
        #1;
        check_eq("bp_rel_gnt", gnt, 3'b001);
        check_eq("bp_rel_rready", s_r_ready, 1'b1);
        check_eq("bp_rel_addr", s_addr, 32'h10);
        tick();
        req[0]    = 1'b0;
        s_r_valid = 1'b0;
        #1;
        check_eq("bp_idle_rvalid", r_valid, 3'b000);

        // Reset mid-read: pending response is dropped, pointer returns to 0.
        addr[1] = 32'h44;
        req[1]  = 1'b1;
        #1;
        check_eq("mid_gnt1", gnt, 3'b010);
        tick();
        req[1]    = 1'b0;
        resetn    = 1'b0;
        s_r_valid = 1'b1;
        #1;
        check_eq("mid_rst_rvalid", r_valid, 3'b000);
        check_eq("mid_rst_rready", s_r_ready, 1'b0);
        tick();
        resetn    = 1'b1;
        s_r_valid = 1'b0;
        wen       = '1;
        req       = '1;
        #1;
        check_eq("mid_rel_gnt", gnt, 3'b001);
        tick();
        req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
